bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised N-core shared-bus arbiter. Successor to the fixed two-core grant/flush steering in the multicore top level.
- Grants exclusive bus tenure to one core at a time using round-robin fairness. Flush (write-back) requests take priority over normal requests.
- While a flush tenure is active, steers the owner's write-back data and tag toward the L2.
- Adds a hold watchdog that forcibly revokes a stuck tenure.

Parameters:
- NUM_CORES, 4, number of cores/request channels (2..16).
- DATA_W, 32, width of write-back data per core.
- TAG_W, 24, width of write-back tag per core.
- MAX_HOLD, 16, maximum tenure length in cycles before forced release (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_CORES  per-core normal bus request, level.
- flush_i  input  NUM_CORES  per-core write-back request, level.
- release_i  input  NUM_CORES  per-core end-of-tenure strobe.
- data_to_L2_i  input  NUM_CORES*DATA_W  packed write-back data; core k at [k*DATA_W +: DATA_W].
- tag_to_L2_i  input  NUM_CORES*TAG_W  packed write-back tags; core k at [k*TAG_W +: TAG_W].
- grant_o  output  NUM_CORES  one-hot grant, or all-zero; registered.
- stall_o  output  NUM_CORES  core is requesting but not granted.
- owner_o  output  $clog2(NUM_CORES)  index of current owner; valid only while owner_valid_o.
- owner_valid_o  output  1  a tenure is active.
- flush_o  output  1  current tenure is a flush tenure; registered.
- data_to_L2_o  output  DATA_W  owner's data_to_L2_i slice while flush_o, else 0.
- tag_to_L2_o  output  TAG_W  owner's tag_to_L2_i slice while flush_o, else 0.
- timeout_o  output  1  one-cycle pulse when the watchdog revokes a tenure.

Behaviour:
- Reset (synchronous):
  - grant_o=0, owner_valid_o=0, owner_o=0, flush_o=0, timeout_o=0, hold counter=0, state=IDLE.
  - Round-robin pointer last=NUM_CORES-1, so core 0 has first priority.
- States: IDLE, GRANT.
- IDLE:
  - Each cycle, form cand = flush_i if |flush_i, else req_i.
  - If cand != 0, pick the first set bit searching from (last+1) mod NUM_CORES upward with wrap.
  - On the next edge: grant_o = onehot(pick), owner_o = pick, owner_valid_o = 1, flush_o = |flush_i (class captured at grant), hold = 0, state = GRANT.
  - Latency: request sampled at edge t, so grant_o is visible in the cycle after edge t.
- GRANT:
  - Tenure is held regardless of req_i/flush_i changes. Dropping a request does not end tenure; only release or timeout does.
  - release_i[owner]=1 at an edge: grant_o=0, owner_valid_o=0, flush_o=0, last=owner, state=IDLE.
  - release_i on a non-owner bit is ignored.
  - hold increments every GRANT cycle, saturating.
  - If hold==MAX_HOLD-1 and no owner release at that edge: forced release with the same updates as a normal release, plus timeout_o=1 for exactly one cycle.
  - Owner release and timeout at the same edge: treated as a normal release; no timeout pulse.
- Turnaround: after any release, at least one IDLE cycle with grant_o=0 before the next grant. Back-to-back tenures are therefore separated by exactly one idle cycle when requests are pending.
- Fairness:
  - The pointer advances only on tenure end, to the ending owner.
  - A continuously requesting core waits at most NUM_CORES-1 tenures within its class.
  - Flush class strictly preempts normal class at arbitration; it does not preempt an active tenure.
- stall_o[k] = (req_i[k] | flush_i[k]) & ~grant_o[k]. Combinational from registered grant; 0 during reset.
- Data/tag steering is a combinational mux on the registered owner_o, gated by flush_o. The output changes with the owner's inputs during tenure.
- grant_o is always one-hot or zero. owner_valid_o == |grant_o. Both are assertion targets.

Test Plan:
- Single requester: NUM_CORES=4, req_i=4'b0100 from cycle 2, release_i[2] pulsed 3 cycles after grant.
  -> grant_o=0100 one cycle after sampling; owner_o=2; flush_o=0; grant drops after the release edge; stall_o=0 throughout the tenure.
- All cores requesting continuously, each releasing after 2 grant cycles.
  -> grant order 0,1,2,3,0 with one idle cycle between tenures; stall_o set for the three waiting cores.
- req_i=1111 and flush_i=0010, last=0.
  -> core 1 granted with flush_o=1; data_to_L2_o equals core 1 slice (drive 32'hDEADBEEF); tag_to_L2_o equals core 1 tag (24'hABCDEF); normal cores follow only after release.
- Owner never releases, MAX_HOLD=16.
  -> grant_o drops after 16 tenure cycles, timeout_o high for exactly 1 cycle, next requester in RR order granted after one idle cycle.
- Owner 1 granted; release_i=4'b1000 asserted.
  -> ignored, tenure continues. Then reset asserted mid-tenure -> next cycle all outputs 0, and the first grant after reset goes to the lowest-index requester.
- Owner release and timeout at the same edge (release_i[owner] at hold=MAX_HOLD-1).
  -> normal release, timeout_o stays 0.

Source files
------------

// File: rtl/bus_arbiter_rr_if.sv
// Bus-side signal bundle for the round-robin arbiter.
// The slave modport is the arbiter's view. The master modport is the cores' view.
interface bus_arbiter_rr_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 24
);
  localparam int unsigned OwnerW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]        req_i;
  logic [NUM_CORES-1:0]        flush_i;
  logic [NUM_CORES-1:0]        release_i;
  logic [NUM_CORES*DATA_W-1:0] data_to_L2_i;
  logic [NUM_CORES*TAG_W-1:0]  tag_to_L2_i;
  logic [NUM_CORES-1:0]        grant_o;
  logic [NUM_CORES-1:0]        stall_o;
  logic [OwnerW-1:0]           owner_o;
  logic                        owner_valid_o;
  logic                        flush_o;
  logic [DATA_W-1:0]           data_to_L2_o;
  logic [TAG_W-1:0]            tag_to_L2_o;
  logic                        timeout_o;

  modport slave (
    input  req_i, flush_i, release_i, data_to_L2_i, tag_to_L2_i,
    output grant_o, stall_o, owner_o, owner_valid_o, flush_o,
           data_to_L2_o, tag_to_L2_o, timeout_o
  );

  modport master (
    output req_i, flush_i, release_i, data_to_L2_i, tag_to_L2_i,
    input  grant_o, stall_o, owner_o, owner_valid_o, flush_o,
           data_to_L2_o, tag_to_L2_o, timeout_o
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// N-core round-robin bus arbiter.
// Flush requests win arbitration over normal requests.
// A flush tenure steers the owner's write-back data and tag to the L2.
// A hold watchdog revokes any tenure that outlives MAX_HOLD cycles.
module bus_arbiter_rr #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 24,
  parameter int unsigned MAX_HOLD  = 16
) (
  input logic              clk,
  input logic              reset,
  bus_arbiter_rr_if.slave  bus
);
  localparam int unsigned OwnerW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned HoldW  = $clog2(MAX_HOLD) + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [OwnerW-1:0]    owner_q, owner_d;
  logic [OwnerW-1:0]    last_q, last_d;
  logic                 flush_q, flush_d;
  logic                 timeout_q, timeout_d;
  logic [HoldW-1:0]     hold_q, hold_d;

  logic [NUM_CORES-1:0] cand;
  logic [OwnerW-1:0]    pick;
  logic                 pick_valid;
  logic [31:0]          scan_idx;
  logic                 owner_rel;

  // Rotating-priority search: the first candidate after the last owner, with wrap-around.
  always_comb begin
    cand       = (|bus.flush_i) ? bus.flush_i : bus.req_i;
    pick       = '0;
    pick_valid = 1'b0;
    scan_idx   = '0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      scan_idx = (32'(last_q) + i) % NUM_CORES;
      if (!pick_valid && cand[scan_idx[OwnerW-1:0]]) begin
        pick       = scan_idx[OwnerW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  // Tenure FSM: grant from IDLE, end the tenure on owner release or watchdog expiry.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    flush_d   = flush_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    owner_rel = bus.release_i[owner_q];
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          grant_d = NUM_CORES'(1) << pick;
          owner_d = pick;
          flush_d = |bus.flush_i;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (hold_q != HoldLast) hold_d = hold_q + 1'b1;
        // An owner release wins over a coincident watchdog expiry, so no timeout pulse.
        if (owner_rel || (hold_q == HoldLast)) begin
          state_d   = StIdle;
          grant_d   = '0;
          flush_d   = 1'b0;
          last_d    = owner_q;
          hold_d    = '0;
          timeout_d = !owner_rel;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  // The pointer resets to the top core so that core 0 has first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= OwnerW'(NUM_CORES - 1);
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  // Output decode and write-back steering from the registered owner.
  always_comb begin
    bus.grant_o       = grant_q;
    bus.owner_o       = owner_q;
    bus.owner_valid_o = (state_q == StGrant);
    bus.flush_o       = flush_q;
    bus.timeout_o     = timeout_q;
    bus.stall_o       = reset ? '0 : ((bus.req_i | bus.flush_i) & ~grant_q);
    bus.data_to_L2_o  = '0;
    bus.tag_to_L2_o   = '0;
    if (flush_q) begin
      bus.data_to_L2_o = bus.data_to_L2_i[32'(owner_q) * DATA_W +: DATA_W];
      bus.tag_to_L2_o  = bus.tag_to_L2_i[32'(owner_q) * TAG_W +: TAG_W];
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_owner_valid:  assert property (@(posedge clk) disable iff (reset)
                                   ((state_q == StGrant) == (|grant_q)));
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr.
// A vector table covers single-owner, round-robin and flush behaviour.
// Hand-written sequences cover the watchdog, release/timeout collision, and reset mid-tenure.
module tb_bus_arbiter_rr;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 24;
  localparam int unsigned MH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_CORES(N), .DATA_W(DW), .TAG_W(TW)) bus ();

  bus_arbiter_rr #(
    .NUM_CORES(N), .DATA_W(DW), .TAG_W(TW), .MAX_HOLD(MH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] flush;
    logic [3:0] rel;
    logic [3:0] grant;
    logic       ov;
    logic [1:0] owner;
    logic       fl;
    logic       to;
    logic [3:0] stall;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] data_tab [N];
  logic [23:0] tag_tab  [N];

  function automatic vec_t v(logic rst, logic [3:0] req, logic [3:0] flush, logic [3:0] rel,
                             logic [3:0] grant, logic ov, logic [1:0] owner, logic fl,
                             logic to, logic [3:0] stall);
    vec_t r;
    r.rst = rst; r.req = req; r.flush = flush; r.rel = rel; r.grant = grant;
    r.ov = ov; r.owner = owner; r.fl = fl; r.to = to; r.stall = stall;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic saw_to;

    data_tab[0] = 32'h0BAD_0000; data_tab[1] = 32'hDEAD_BEEF;
    data_tab[2] = 32'h2222_2222; data_tab[3] = 32'h3333_3333;
    tag_tab[0]  = 24'h00_0A0A;   tag_tab[1]  = 24'hAB_CDEF;
    tag_tab[2]  = 24'h22_2222;   tag_tab[3]  = 24'h33_3333;
    for (int k = 0; k < N; k++) begin
      bus.data_to_L2_i[k*DW +: DW] = data_tab[k];
      bus.tag_to_L2_i[k*TW +: TW]  = tag_tab[k];
    end

    // Fields: rst req flush rel | grant ov owner fl to stall.
    // Single requester on core 2.
    vecs.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 4'b0000));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 4'b0000));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 4'b0000));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 0, 4'b0100));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000));
    // Reset with requests pending: stall is held low.
    vecs.push_back(v(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000));
    // All cores request. Each holds for two cycles and then releases.
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0, 4'b1110));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0, 4'b1110));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0, 4'b1101));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0, 4'b1101));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 4'b1011));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 4'b1011));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 3, 0, 0, 4'b0111));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 3, 0, 0, 4'b0111));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0, 4'b1110));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b1111));
    // Flush on core 1 with last=0. Dropping the flush request keeps the tenure.
    vecs.push_back(v(0, 4'b1111, 4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 0, 4'b1101));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 1, 1, 0, 4'b1101));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0, 4'b1111));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 4'b1011));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 0, 4'b1111));
    // With last=2, normal order would pick core 3. The flush on core 0 wins.
    vecs.push_back(v(0, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 0, 4'b1110));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000));

    reset = 1'b1;
    bus.req_i = '0; bus.flush_i = '0; bus.release_i = '0;
    @(negedge clk);
    step();
    check("rst_grant", 32'(bus.grant_o), 0);
    check("rst_owner_valid", 32'(bus.owner_valid_o), 0);
    check("rst_owner", 32'(bus.owner_o), 0);
    check("rst_flush", 32'(bus.flush_o), 0);
    check("rst_timeout", 32'(bus.timeout_o), 0);
    check("rst_data", bus.data_to_L2_o, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      reset         = vecs[i].rst;
      bus.req_i     = vecs[i].req;
      bus.flush_i   = vecs[i].flush;
      bus.release_i = vecs[i].rel;
      step();
      check($sformatf("v%0d_grant", i), 32'(bus.grant_o), 32'(vecs[i].grant));
      check($sformatf("v%0d_owner_valid", i), 32'(bus.owner_valid_o), 32'(vecs[i].ov));
      if (vecs[i].ov) check($sformatf("v%0d_owner", i), 32'(bus.owner_o), 32'(vecs[i].owner));
      check($sformatf("v%0d_flush", i), 32'(bus.flush_o), 32'(vecs[i].fl));
      check($sformatf("v%0d_timeout", i), 32'(bus.timeout_o), 32'(vecs[i].to));
      check($sformatf("v%0d_stall", i), 32'(bus.stall_o), 32'(vecs[i].stall));
      check($sformatf("v%0d_data", i), bus.data_to_L2_o,
            vecs[i].fl ? data_tab[vecs[i].owner] : 32'h0);
      check($sformatf("v%0d_tag", i), 32'(bus.tag_to_L2_o),
            vecs[i].fl ? 32'(tag_tab[vecs[i].owner]) : 32'h0);
    end
    reset = 1'b0;
    bus.req_i = '0; bus.flush_i = '0; bus.release_i = '0;

    // Watchdog: core 0 never releases. Core 1 waits.
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_i = 4'b0011;
    step();
    check("wd_first_grant", 32'(bus.grant_o), 32'h1);
    cnt = 1;
    saw_to = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.timeout_o && bus.grant_o == 4'b0001) saw_to = 1'b1;
      if (bus.grant_o != 4'b0001) break;
      cnt++;
    end
    check("wd_tenure_len", 32'(cnt), MH);
    check("wd_no_early_pulse", 32'(saw_to), 0);
    check("wd_grant_dropped", 32'(bus.grant_o), 0);
    check("wd_owner_valid", 32'(bus.owner_valid_o), 0);
    check("wd_timeout_pulse", 32'(bus.timeout_o), 1);
    step();
    check("wd_timeout_one_cycle", 32'(bus.timeout_o), 0);
    check("wd_next_grant", 32'(bus.grant_o), 32'h2);
    check("wd_next_owner", 32'(bus.owner_o), 1);

    // Owner release coincides with watchdog expiry: a normal release, so no pulse.
    repeat (MH - 1) step();
    check("col_still_granted", 32'(bus.grant_o), 32'h2);
    bus.release_i = 4'b0010;
    bus.req_i     = 4'b0000;
    step();
    check("col_grant", 32'(bus.grant_o), 0);
    check("col_timeout", 32'(bus.timeout_o), 0);
    bus.release_i = 4'b0000;
    step();
    check("col_timeout_after", 32'(bus.timeout_o), 0);

    // A release on a non-owner bit is ignored. Then reset is asserted mid-tenure.
    bus.req_i = 4'b0010;
    step();
    check("nr_grant", 32'(bus.grant_o), 32'h2);
    bus.release_i = 4'b1000;
    step();
    check("nr_ignored_grant", 32'(bus.grant_o), 32'h2);
    check("nr_ignored_valid", 32'(bus.owner_valid_o), 1);
    bus.release_i = 4'b0000;
    bus.req_i     = 4'b1110;
    reset         = 1'b1;
    step();
    check("mr_grant", 32'(bus.grant_o), 0);
    check("mr_owner_valid", 32'(bus.owner_valid_o), 0);
    check("mr_owner", 32'(bus.owner_o), 0);
    check("mr_flush", 32'(bus.flush_o), 0);
    check("mr_stall", 32'(bus.stall_o), 0);
    reset = 1'b0;
    step();
    check("mr_first_grant", 32'(bus.grant_o), 32'h2);
    check("mr_first_owner", 32'(bus.owner_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
